// File: rtl/audio_clip_scheduler.sv
// audio_clip_scheduler
//   Shares one waveform ROM between looping background music (clip 0) and
//   one-shot sound effects (clips 1..N_CLIP-1). Effects take priority over
//   music, higher effect indices preempt lower ones, and preempted music
//   resumes where it left off. One ROM step is taken every HOLD_TIME clocks.
//   Each address is followed ROM_LAT clocks later by a registered sample.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-low reset
//   music_en      level, background music enabled
//   sfx_req       one-cycle request pulses, bit k requests clip k+1
//   rom_data      ROM read data, valid ROM_LAT clocks after rom_addr changes
//   rom_addr      CLIP_BASE[active] + offset (0 while idle)
//   sample        current audio sample, held between updates (0 while idle)
//   sample_valid  one-cycle pulse when sample updates
//   active_clip   effect clip being addressed (0 when idle or playing music)
//   busy          music or an effect is playing
//   sfx_done      one-cycle pulse when an effect plays its last sample
module audio_clip_scheduler #(
    parameter int                      HOLD_TIME = 52500,
    parameter int                      N_CLIP    = 4,
    parameter int                      ADDR_W    = 16,
    parameter logic [N_CLIP*ADDR_W-1:0] CLIP_BASE = {16'd62000, 16'd60000, 16'd58000, 16'd0},
    parameter logic [N_CLIP*16-1:0]     CLIP_LEN  = {16'd1500, 16'd2000, 16'd2000, 16'd58000},
    parameter int                      ROM_LAT   = 2,
    parameter int                      DATA_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      music_en,
    input  logic [N_CLIP-2:0]         sfx_req,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic [DATA_W-1:0]         sample,
    output logic                      sample_valid,
    output logic [$clog2(N_CLIP)-1:0] active_clip,
    output logic                      busy,
    output logic                      sfx_done
);

    localparam int CLIP_W = $clog2(N_CLIP);
    localparam int LEN_W  = 16;

    function automatic int max_len();
        int m;
        m = 1;
        for (int i = 0; i < N_CLIP; i++) begin
            if (int'(CLIP_LEN[i*LEN_W +: LEN_W]) > m) m = int'(CLIP_LEN[i*LEN_W +: LEN_W]);
        end
        return m;
    endfunction

    localparam int MAX_LEN = max_len();
    localparam int OFF_W   = ($clog2(MAX_LEN) < 1) ? 1 : $clog2(MAX_LEN);
    localparam int CNT_W   = ($clog2(HOLD_TIME) < 1) ? 1 : $clog2(HOLD_TIME);

    typedef enum logic [1:0] {S_IDLE, S_MUSIC, S_SFX} state_t;

    function automatic logic [ADDR_W-1:0] clip_base(input logic [CLIP_W-1:0] c);
        return CLIP_BASE[int'(c)*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [OFF_W-1:0] clip_last(input logic [CLIP_W-1:0] c);
        return OFF_W'(CLIP_LEN[int'(c)*LEN_W +: LEN_W] - 16'd1);
    endfunction

    // Highest requested effect index, 0 when nothing is requested.
    function automatic logic [CLIP_W-1:0] hi_index(input logic [N_CLIP-1:1] p);
        logic [CLIP_W-1:0] idx;
        idx = '0;
        for (int i = 1; i < N_CLIP; i++) begin
            if (p[i]) idx = CLIP_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [N_CLIP-1:1] clip_mask(input logic [CLIP_W-1:0] c);
        logic [N_CLIP-1:1] m;
        for (int i = 1; i < N_CLIP; i++) m[i] = (c == CLIP_W'(i));
        return m;
    endfunction

    state_t              state_q, state_nxt;
    logic [CLIP_W-1:0]   clip_q, clip_nxt;
    logic [OFF_W-1:0]    off_q, off_nxt;
    logic [OFF_W-1:0]    mus_off_q, mus_off_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic [N_CLIP-1:1]   pending_q, pend_nxt, pend_eff;
    logic [CLIP_W-1:0]   hi;
    logic                pend_any, tick, last, start, adv, done_nxt;
    logic [ROM_LAT-1:0]  vld_p;

    // Requests arriving this cycle take part in the decision immediately,
    // so a preemption lands on the very next address update.
    assign pend_eff = pending_q | sfx_req;
    assign hi       = hi_index(pend_eff);
    assign pend_any = |pend_eff;
    assign tick     = (state_q != S_IDLE) && (cnt_q == CNT_W'(HOLD_TIME - 1));
    assign last     = (off_q == clip_last(clip_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_nxt;
    end

    always_comb begin
        state_nxt   = state_q;
        clip_nxt    = clip_q;
        off_nxt     = off_q;
        mus_off_nxt = mus_off_q;
        pend_nxt    = pend_eff;
        cnt_nxt     = '0;
        start       = 1'b0;
        adv         = 1'b0;
        done_nxt    = 1'b0;

        if (state_q != S_IDLE) cnt_nxt = tick ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (pend_any) begin
                    state_nxt = S_SFX;
                    clip_nxt  = hi;
                    off_nxt   = '0;
                    pend_nxt  = pend_eff & ~clip_mask(hi);
                    start     = 1'b1;
                end else if (music_en) begin
                    state_nxt = S_MUSIC;
                    clip_nxt  = '0;
                    off_nxt   = mus_off_q;
                    start     = 1'b1;
                end
            end
            S_MUSIC: begin
                if (pend_any) begin
                    // Park the music position; a tick this cycle counts as played.
                    mus_off_nxt = tick ? (last ? '0 : off_q + 1'b1) : off_q;
                    state_nxt   = S_SFX;
                    clip_nxt    = hi;
                    off_nxt     = '0;
                    pend_nxt    = pend_eff & ~clip_mask(hi);
                    start       = 1'b1;
                end else if (!music_en) begin
                    state_nxt = S_IDLE;
                    clip_nxt  = '0;
                    off_nxt   = '0;
                end else if (tick) begin
                    off_nxt = last ? '0 : off_q + 1'b1;
                    adv     = 1'b1;
                end
            end
            S_SFX: begin
                // Pending bits below the active clip never preempt; a request at
                // or above it drops the current effect without sfx_done.
                if (pend_any && (hi >= clip_q)) begin
                    clip_nxt = hi;
                    off_nxt  = '0;
                    pend_nxt = pend_eff & ~clip_mask(hi);
                    start    = 1'b1;
                end else if (tick && last) begin
                    done_nxt = 1'b1;
                    if (pend_any) begin
                        clip_nxt = hi;
                        off_nxt  = '0;
                        pend_nxt = pend_eff & ~clip_mask(hi);
                        start    = 1'b1;
                    end else if (music_en) begin
                        state_nxt = S_MUSIC;
                        clip_nxt  = '0;
                        off_nxt   = mus_off_q;
                        start     = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        clip_nxt  = '0;
                        off_nxt   = '0;
                    end
                end else if (tick) begin
                    off_nxt = off_q + 1'b1;
                    adv     = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                clip_nxt  = '0;
                off_nxt   = '0;
            end
        endcase

        if (!music_en) mus_off_nxt = '0;
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        active_clip = (state_q == S_SFX) ? clip_q : '0;
    end

    // Stage p0: sequencing state and ROM address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clip_q    <= '0;
            off_q     <= '0;
            mus_off_q <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            sfx_done  <= 1'b0;
            rom_addr  <= '0;
            vld_p     <= '0;
        end else begin
            clip_q    <= clip_nxt;
            off_q     <= off_nxt;
            mus_off_q <= mus_off_nxt;
            cnt_q     <= cnt_nxt;
            pending_q <= pend_nxt;
            sfx_done  <= done_nxt;
            if (state_nxt == S_IDLE) begin
                rom_addr <= '0;
                vld_p    <= '0;
            end else if (start) begin
                // A clip switch discards every address still in flight.
                rom_addr <= clip_base(clip_nxt) + ADDR_W'(off_nxt);
                vld_p    <= ROM_LAT'(1);
            end else begin
                if (adv) rom_addr <= clip_base(clip_nxt) + ADDR_W'(off_nxt);
                vld_p <= (vld_p << 1) | ROM_LAT'(adv);
            end
        end
    end

    // Stage p1..pROM_LAT: capture ROM data once the surviving address has settled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else if (state_nxt == S_IDLE) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= vld_p[ROM_LAT-1];
            if (vld_p[ROM_LAT-1]) sample <= rom_data;
        end
    end

endmodule
